// File: rtl/lsu_clken_pkg.sv
// lsu_clken_pkg: shared limits, types and hold-counter width helper for the LSU clock-enable controller
package lsu_clken_pkg;
  localparam int MAX_NSTAGE = 8;
  localparam int MAX_NCH = 8;
  localparam int MAX_HOLD = 15;
  typedef logic [MAX_NSTAGE-1:0] clken_vec_t;
  function automatic int hold_w(input int hold_cyc);
    return $clog2(hold_cyc + 1);
  endfunction
endpackage

// File: rtl/lsu_clken_hold.sv
// lsu_clken_hold: keeps an enable high for HOLD_CYC cycles after its last cause
module lsu_clken_hold
  import lsu_clken_pkg::*;
#(
  parameter int HOLD_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cause,
  output logic en
);
  localparam int HOLD_W = hold_w(HOLD_CYC);
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cause ? HOLD_W'(HOLD_CYC) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    en = cause | (cnt_q != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lsu_clken_ctrl.sv
// lsu_clken_ctrl: per-stage, freeze-gated, store and channel clock enables plus bus clock-enable divider
module lsu_clken_ctrl
  import lsu_clken_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int NCH = 4,
  parameter int HOLD_CYC = 1,
  parameter logic [MAX_NSTAGE-1:0] FRZ_MASK = 'h7,
  parameter int RATIO_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_override,
  input  logic               freeze,
  input  logic               dec_vld,
  input  logic               dma_req,
  input  logic               dma_wr,
  input  logic               dec_store,
  input  logic [NSTAGE-1:0]  stg_vld,
  input  logic [NSTAGE-1:0]  stg_store,
  input  logic [NCH-1:0]     ch_req,
  input  logic [NCH-1:0]     ch_busy,
  input  logic [RATIO_W-1:0] bus_ratio,
  output logic [NSTAGE-1:0]  c1_clken,
  output logic [NSTAGE-1:0]  c2_clken,
  output logic [NSTAGE-1:0]  frz_c1_clken,
  output logic [NSTAGE-1:0]  frz_c2_clken,
  output logic [NSTAGE-1:0]  store_clken,
  output logic [NCH-1:0]     ch_clken,
  output logic               bus_clk_en,
  output logic               free_clken
);
  logic [NSTAGE-1:0] c1, c1_d, c1_q, c2, st, gate, frc;
  logic [NCH-1:0] ch;
  logic [RATIO_W-1:0] cnt_q, cnt_d, ratio_q, ratio_d, ratio_cur;
  logic start_q, start_d, wrap, free_cause, free_en, force_all;
  always_comb begin
    c1 = {c1_q[NSTAGE-2:0] | stg_vld[NSTAGE-2:0], dec_vld | dma_req};
    c1_d = c1;
    st = c1 & {stg_store[NSTAGE-2:0], dec_store | dma_wr};
    gate = {NSTAGE{freeze}} & FRZ_MASK[NSTAGE-1:0];
    force_all = rst | clk_override;
    frc = {NSTAGE{force_all}};
    free_cause = dec_vld | dma_req | (|stg_vld) | (|ch_busy);
    c1_clken = c1 | frc;
    c2_clken = c2 | frc;
    frz_c1_clken = (c1 & ~gate) | frc;
    frz_c2_clken = (c2 & ~gate) | frc;
    store_clken = (st & ~gate) | frc;
    ch_clken = ch | {NCH{force_all}};
    free_clken = free_en | force_all;
    // first cycle out of reset runs on the live ratio so the divider restarts immediately
    ratio_cur = start_q ? bus_ratio : ratio_q;
    wrap = cnt_q == ratio_cur;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    ratio_d = wrap ? bus_ratio : ratio_cur;
    start_d = 1'b0;
    bus_clk_en = rst | wrap;
  end
  for (genvar i = 0; i < NSTAGE; i++) begin : g_stg
    lsu_clken_hold #(.HOLD_CYC(HOLD_CYC)) u_hold (.clk(clk), .rst(rst), .cause(c1[i]), .en(c2[i]));
  end
  for (genvar j = 0; j < NCH; j++) begin : g_ch
    lsu_clken_hold #(.HOLD_CYC(HOLD_CYC)) u_hold (.clk(clk), .rst(rst), .cause(ch_req[j] | ch_busy[j]), .en(ch[j]));
  end
  lsu_clken_hold #(.HOLD_CYC(HOLD_CYC)) u_free (.clk(clk), .rst(rst), .cause(free_cause), .en(free_en));
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= '0;
      cnt_q <= '0;
      ratio_q <= '0;
      start_q <= 1'b1;
    end else begin
      c1_q <= c1_d;
      cnt_q <= cnt_d;
      ratio_q <= ratio_d;
      start_q <= start_d;
    end
  end
endmodule
